vvalu_fw_config_sequencer: RTL and testbench
============================================

Name: vvalu_fw_config_sequencer

Overview:
Serialises host firmware-update commands for the vector-vector ALU (per-chain op, rd addr, cond, cache, cache addr) onto the shared 8-bit configId/configData bus. Commands are buffered in a small FIFO and issued only once tracing is low and the ALU pipeline has drained. Updates therefore never land mid-vector. Sits between the host/JTAG config port and every block with a PERSONAL_CONFIG_ID.

Parameters:
MAX_CHAINS, 4, number of firmware chains per target block; chain index width is $clog2(MAX_CHAINS).
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2).
DRAIN_CYCLES, 3, consecutive tracing-low cycles required before the first beat (ALU latency 2 + 1).
IDLE_ID, 8'hFF, configId value driven when no frame is active; never a valid target.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
tracing  in  1  high = datapath live; config frames must not start
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept (= !full)
cmd_target  in  8  PERSONAL_CONFIG_ID of destination block
cmd_field  in  3  0 op, 1 addr_rd, 2 cond, 3 cache, 4 cache_addr; 5-7 illegal
cmd_chain  in  $clog2(MAX_CHAINS)  chain index
cmd_value  in  8  field value
configId  out  8  target ID during a frame, IDLE_ID otherwise
configData  out  8  frame beat payload
busy  out  1  high when the FIFO is non-empty or the FSM is not in WAIT
frame_done  out  1  1-cycle pulse coincident with the value beat
err_bad_field  out  1  sticky: illegal field rejected
err_tracing  out  1  sticky: tracing rose during a frame
err_clear  in  1  synchronous clear of both sticky errors

Behaviour:
- Reset (async, reset_n=0): FIFO emptied, FSM=WAIT, drain counter=0, configId=IDLE_ID, configData=0, frame_done=0, busy=0, both errors=0. A frame aborted by reset is discarded by receivers because configId returns to IDLE_ID.
- All outputs are registered except cmd_ready.
- Accept: cmd_valid&cmd_ready at a rising edge.
  - cmd_field>4: not enqueued; err_bad_field<=1; cmd_ready unaffected.
- FIFO: push and pop in the same edge are legal when non-empty; occupancy is unchanged. Push when full is impossible (ready=0).
- Drain counter (sat. DRAIN_CYCLES):
  - Reset to 0 on any cycle with tracing=1.
  - Increments while tracing=0 in WAIT.
- FSM states:
  - WAIT: configId=IDLE_ID. If counter==DRAIN_CYCLES and FIFO non-empty and tracing=0: latch the FIFO head into the frame register, pop, go to F_FIELD.
  - F_FIELD: configId=target, configData={5'b0,field}. Next state F_CHAIN.
  - F_CHAIN: configData=chain, zero-extended. Next state F_VALUE.
  - F_VALUE: configData=value, frame_done=1. Next state GAP.
  - GAP: configId=IDLE_ID for exactly one cycle. If tracing=0 and FIFO non-empty: latch+pop and go to F_FIELD (counter kept saturated). Else go to WAIT; counter resets to 0 if tracing=1.
- Timing: with the counter already saturated, accept at edge E0 gives beats visible E1-E2 (field), E2-E3 (chain), E3-E4 (value), and GAP at E4-E5. Sustained throughput is 1 command per 4 cycles.
- Frames are atomic. If tracing rises in F_FIELD/F_CHAIN/F_VALUE, the frame completes, err_tracing<=1, and the FSM returns to WAIT after GAP.
- err_clear and a simultaneous error event: the set wins.
- busy = (FIFO non-empty) | (state!=WAIT).

Decomposition:
- Package lebug_cfg_pkg:
  - field-code enum (FW_OP..FW_CACHE_ADDR)
  - FSM state enum
  - IDLE_ID default
  - cmd struct {target, field, chain, value}
- Sub-module cfg_cmd_fifo: synchronous FIFO, async active-low reset, width = struct width, depth FIFO_DEPTH, with full/empty flags.

Test Plan:
- Reset, hold tracing=0 for 5 cycles, push {target 2, field 1, chain 3, value 8'h05} -> beats (2,8'h01),(2,8'h03),(2,8'h05) on E1..E3, frame_done on the 3rd beat, then configId=8'hFF.
- Tracing=1, push 4 commands -> 5th cmd_ready=0 and no beats. Drop tracing -> first beat exactly DRAIN_CYCLES+1 cycles after the fall; 4 frames each separated by one IDLE_ID gap; busy falls after the last GAP.
- Push field=6 -> err_bad_field=1, FIFO stays empty, no frame. Assert err_clear -> flag clears.
- Raise tracing during F_CHAIN -> value beat still issued, err_tracing=1. Next queued frame waits for tracing low plus DRAIN_CYCLES.
- Assert reset_n=0 during F_CHAIN with 2 commands queued -> configId=8'hFF immediately (async), busy=0, no frames after release until new pushes.
- Push and pop in the same edge with the FIFO at 3/4 -> occupancy unchanged, command order preserved.

Source files
------------

// File: rtl/lebug_cfg_pkg.sv
// ---------------------------------------------------------------------------
// lebug_cfg_pkg
// Shared types and constants for the vector-vector ALU firmware config
// sequencer: firmware field codes, sequencer FSM states, the buffered host
// command record and the bus idle ID.
// ---------------------------------------------------------------------------
package lebug_cfg_pkg;

    localparam int         MAX_CHAINS   = 4;
    localparam int         CHAIN_W      = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
    localparam int         FIFO_DEPTH   = 4;   // power of 2, >= 2
    localparam int         DRAIN_CYCLES = 3;   // ALU latency 2 + 1
    localparam logic [7:0] IDLE_ID      = 8'hFF;

    typedef enum logic [2:0] {
        FW_OP         = 3'd0,
        FW_ADDR_RD    = 3'd1,
        FW_COND       = 3'd2,
        FW_CACHE      = 3'd3,
        FW_CACHE_ADDR = 3'd4
    } fw_field_e;

    typedef enum logic [2:0] {
        S_WAIT,
        S_FIELD,
        S_CHAIN,
        S_VALUE,
        S_GAP
    } seq_state_e;

    typedef struct packed {
        logic [7:0]         target;
        fw_field_e          field;
        logic [CHAIN_W-1:0] chain;
        logic [7:0]         value;
    } cfg_cmd_t;

    localparam int CMD_W = $bits(cfg_cmd_t);

    // Codes 5..7 have no receiver-side meaning and are rejected at the port.
    function automatic logic field_legal(input logic [2:0] f);
        return f <= FW_CACHE_ADDR;
    endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cfg_cmd_fifo
// Synchronous FIFO holding pending firmware commands. Head is presented
// combinationally on rdata; push and pop may share an edge.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    write strobe and data (caller never pushes when full)
//   pop, rdata     read strobe and head-of-queue data (caller never pops empty)
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module cfg_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int          AW       = $clog2(DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state flops use non-blocking assignments so all flops update together.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers/count alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/vvalu_fw_config_sequencer.sv
// ---------------------------------------------------------------------------
// vvalu_fw_config_sequencer
// Buffers host firmware-update commands and serialises each one as a
// three-beat frame (field, chain, value) on the shared configId/configData
// bus, only after tracing has been low for DRAIN_CYCLES cycles so updates
// never land mid-vector.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   tracing               datapath live; frames must not start
//   cmd_valid/cmd_ready   host command handshake (ready = FIFO not full)
//   cmd_target/field/chain/value   command contents
//   configId, configData  registered config bus (IDLE_ID when idle)
//   busy                  FIFO non-empty or a frame in flight
//   frame_done            pulse with the value beat
//   err_bad_field         sticky: illegal field code rejected
//   err_tracing           sticky: tracing rose during a frame
//   err_clear             synchronous clear of both errors (set wins)
// ---------------------------------------------------------------------------
module vvalu_fw_config_sequencer
    import lebug_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tracing,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [7:0]         cmd_target,
    input  logic [2:0]         cmd_field,
    input  logic [CHAIN_W-1:0] cmd_chain,
    input  logic [7:0]         cmd_value,
    output logic [7:0]         configId,
    output logic [7:0]         configData,
    output logic               busy,
    output logic               frame_done,
    output logic               err_bad_field,
    output logic               err_tracing,
    input  logic               err_clear
);

    localparam int                 DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);

    logic             accept, push, pop;
    logic             fifo_full, fifo_empty, fifo_nonempty_d;
    logic [CMD_W-1:0] fifo_rdata;
    cfg_cmd_t         cmd_in, head;

    seq_state_e         state_q, state_d;
    cfg_cmd_t           frame_q, frame_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               launch_ok;

    logic [7:0] config_id_q, config_id_d;
    logic [7:0] config_data_q, config_data_d;
    logic       frame_done_q, frame_done_d;
    logic       busy_q, busy_d;
    logic       err_bad_field_q, err_bad_field_d;
    logic       err_tracing_q, err_tracing_d;

    assign cmd_ready = !fifo_full;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = accept && field_legal(cmd_field);
    assign cmd_in    = '{target: cmd_target, field: fw_field_e'(cmd_field),
                         chain: cmd_chain, value: cmd_value};
    assign head      = cfg_cmd_t'(fifo_rdata);

    cfg_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (cmd_in),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A new frame may start only with a saturated drain count and tracing
    // still low; the count is cleared by any tracing cycle, which also keeps
    // GAP from chaining straight into the next frame after an in-frame rise.
    assign launch_ok = (drain_q == DRAIN_MAX) && !tracing && !fifo_empty;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        pop     = 1'b0;
        drain_d = drain_q;

        if (tracing) begin
            drain_d = '0;
        end else if (state_q == S_WAIT && drain_q != DRAIN_MAX) begin
            drain_d = drain_q + DRAIN_W'(1);
        end

        case (state_q)
            S_WAIT, S_GAP: begin
                if (launch_ok) begin
                    frame_d = head;
                    pop     = 1'b1;
                    state_d = S_FIELD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FIELD: state_d = S_CHAIN;
            S_CHAIN: state_d = S_VALUE;
            S_VALUE: state_d = S_GAP;
            default: state_d = S_WAIT;
        endcase
    end

    // Bus outputs are registered from the next state so the field beat is
    // visible in the same cycle the FSM enters F_FIELD.
    always_comb begin
        config_id_d   = IDLE_ID;
        config_data_d = '0;
        frame_done_d  = 1'b0;
        case (state_d)
            S_FIELD: begin
                config_id_d   = frame_d.target;
                config_data_d = {5'b0, frame_d.field};
            end
            S_CHAIN: begin
                config_id_d   = frame_d.target;
                config_data_d = {{(8-CHAIN_W){1'b0}}, frame_d.chain};
            end
            S_VALUE: begin
                config_id_d   = frame_d.target;
                config_data_d = frame_d.value;
                frame_done_d  = 1'b1;
            end
            default: ;
        endcase

        fifo_nonempty_d = push || (!fifo_empty && !pop) || (!fifo_empty && push);
        busy_d          = fifo_nonempty_d || (state_d != S_WAIT);

        err_bad_field_d = (err_bad_field_q && !err_clear) ||
                          (accept && !field_legal(cmd_field));
        err_tracing_d   = (err_tracing_q && !err_clear) ||
                          (tracing && (state_q == S_FIELD || state_q == S_CHAIN ||
                                       state_q == S_VALUE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_WAIT;
            frame_q         <= '0;
            drain_q         <= '0;
            config_id_q     <= IDLE_ID;
            config_data_q   <= '0;
            frame_done_q    <= 1'b0;
            busy_q          <= 1'b0;
            err_bad_field_q <= 1'b0;
            err_tracing_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            frame_q         <= frame_d;
            drain_q         <= drain_d;
            config_id_q     <= config_id_d;
            config_data_q   <= config_data_d;
            frame_done_q    <= frame_done_d;
            busy_q          <= busy_d;
            err_bad_field_q <= err_bad_field_d;
            err_tracing_q   <= err_tracing_d;
        end
    end

    assign configId      = config_id_q;
    assign configData    = config_data_q;
    assign frame_done    = frame_done_q;
    assign busy          = busy_q;
    assign err_bad_field = err_bad_field_q;
    assign err_tracing   = err_tracing_q;

endmodule

// File: tb/tb_vvalu_fw_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vvalu_fw_config_sequencer
// Directed bench for the firmware config sequencer. Each scenario task
// drives its own stimulus and compares against hand-derived expectations.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_vvalu_fw_config_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tracing;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_target;
    logic [2:0] cmd_field;
    logic [1:0] cmd_chain;
    logic [7:0] cmd_value;
    logic [7:0] configId;
    logic [7:0] configData;
    logic       busy;
    logic       frame_done;
    logic       err_bad_field;
    logic       err_tracing;
    logic       err_clear;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vvalu_fw_config_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tracing       (tracing),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_target    (cmd_target),
        .cmd_field     (cmd_field),
        .cmd_chain     (cmd_chain),
        .cmd_value     (cmd_value),
        .configId      (configId),
        .configData    (configData),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_bad_field (err_bad_field),
        .err_tracing   (err_tracing),
        .err_clear     (err_clear)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command across exactly one rising edge.
    task automatic push(input logic [7:0] t, input logic [2:0] f,
                        input logic [1:0] c, input logic [7:0] v);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_field  = f;
        cmd_chain  = c;
        cmd_value  = v;
        step(1);
        cmd_valid  = 1'b0;
    endtask

    // Expected {id,data,done} x3 beats followed by the GAP id.
    function automatic logic [58:0] exp_frame(input logic [7:0] t, input logic [2:0] f,
                                              input logic [1:0] c, input logic [7:0] v);
        return {t, 5'b0, f, 1'b0, t, 6'b0, c, 1'b0, t, v, 1'b1, 8'hFF};
    endfunction

    // Sample the next three beats and the GAP cycle.
    task automatic grab_frame(output logic [58:0] obs);
        logic [16:0] b [3];
        for (int i = 0; i < 3; i++) begin
            step(1);
            b[i] = {configId, configData, frame_done};
        end
        step(1);
        obs = {b[0], b[1], b[2], configId};
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        tracing   = 1'b0;
        cmd_valid = 1'b0;
        cmd_target = '0;
        cmd_field = '0;
        cmd_chain = '0;
        cmd_value = '0;
        err_clear = 1'b0;
        step(2);
        n_vec++;
        if ({configId, configData, busy, frame_done, err_bad_field, err_tracing, cmd_ready}
            !== {8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state got id=%h data=%h busy=%b done=%b eb=%b et=%b rdy=%b want FF 00 0 0 0 0 1",
                     configId, configData, busy, frame_done, err_bad_field, err_tracing, cmd_ready);
            n_err++;
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [58:0] obs;
        step(5);
        push(8'd2, 3'd1, 2'd3, 8'h05);
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL single_busy got %b want 1", busy);
            n_err++;
        end
        grab_frame(obs);
        n_vec++;
        if (obs !== exp_frame(8'd2, 3'd1, 2'd3, 8'h05)) begin
            $display("FAIL single_frame got %h want %h", obs, exp_frame(8'd2, 3'd1, 2'd3, 8'h05));
            n_err++;
        end
        step(1);
        n_vec++;
        if ({busy, configId} !== {1'b0, 8'hFF}) begin
            $display("FAIL single_idle got busy=%b id=%h want 0 FF", busy, configId);
            n_err++;
        end
    endtask

    task automatic test_backlog();
        logic [58:0] obs;
        logic [58:0] exp [4];
        exp[0] = exp_frame(8'h10, 3'd0, 2'd0, 8'hA0);
        exp[1] = exp_frame(8'h11, 3'd2, 2'd1, 8'hA1);
        exp[2] = exp_frame(8'h12, 3'd3, 2'd2, 8'hA2);
        exp[3] = exp_frame(8'h13, 3'd4, 2'd3, 8'hA3);
        tracing = 1'b1;
        push(8'h10, 3'd0, 2'd0, 8'hA0);
        push(8'h11, 3'd2, 2'd1, 8'hA1);
        push(8'h12, 3'd3, 2'd2, 8'hA2);
        push(8'h13, 3'd4, 2'd3, 8'hA3);
        n_vec++;
        if ({cmd_ready, busy, configId} !== {1'b0, 1'b1, 8'hFF}) begin
            $display("FAIL backlog_full got rdy=%b busy=%b id=%h want 0 1 FF", cmd_ready, busy, configId);
            n_err++;
        end
        push(8'h14, 3'd0, 2'd0, 8'hA4);  // refused: FIFO full
        step(1);
        n_vec++;
        if ({cmd_ready, configId} !== {1'b0, 8'hFF}) begin
            $display("FAIL backlog_hold got rdy=%b id=%h want 0 FF", cmd_ready, configId);
            n_err++;
        end
        tracing = 1'b0;
        step(3);
        n_vec++;
        if (configId !== 8'hFF) begin
            $display("FAIL drain_early got id=%h want FF", configId);
            n_err++;
        end
        for (int i = 0; i < 4; i++) begin
            grab_frame(obs);
            n_vec++;
            if (obs !== exp[i]) begin
                $display("FAIL backlog_frame%0d got %h want %h", i, obs, exp[i]);
                n_err++;
            end
        end
        step(1);
        n_vec++;
        if ({busy, cmd_ready} !== 2'b01) begin
            $display("FAIL backlog_done got busy=%b rdy=%b want 0 1", busy, cmd_ready);
            n_err++;
        end
    endtask

    task automatic test_bad_field();
        logic bad;
        push(8'h09, 3'd6, 2'd0, 8'hAA);
        n_vec++;
        if ({err_bad_field, busy} !== 2'b10) begin
            $display("FAIL bad_field_set got err=%b busy=%b want 1 0", err_bad_field, busy);
            n_err++;
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (configId !== 8'hFF || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad !== 1'b0) begin
            $display("FAIL bad_field_noframe got activity=%b want 0", bad);
            n_err++;
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        n_vec++;
        if (err_bad_field !== 1'b0) begin
            $display("FAIL bad_field_clear got %b want 0", err_bad_field);
            n_err++;
        end
        err_clear = 1'b1;
        push(8'h09, 3'd7, 2'd0, 8'hAA);
        err_clear = 1'b0;
        n_vec++;
        if (err_bad_field !== 1'b1) begin
            $display("FAIL set_wins got %b want 1", err_bad_field);
            n_err++;
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
    endtask

    task automatic test_tracing_mid();
        logic [58:0] obs;
        push(8'd3, 3'd0, 2'd1, 8'h11);
        push(8'd4, 3'd2, 2'd2, 8'h22);
        n_vec++;
        if ({configId, configData} !== {8'd3, 8'h00}) begin
            $display("FAIL mid_field got %h %h want 03 00", configId, configData);
            n_err++;
        end
        step(1);
        n_vec++;
        if ({configId, configData} !== {8'd3, 8'h01}) begin
            $display("FAIL mid_chain got %h %h want 03 01", configId, configData);
            n_err++;
        end
        tracing = 1'b1;
        step(1);
        n_vec++;
        if ({configId, configData, frame_done, err_tracing} !== {8'd3, 8'h11, 1'b1, 1'b1}) begin
            $display("FAIL mid_value got id=%h data=%h done=%b et=%b want 03 11 1 1",
                     configId, configData, frame_done, err_tracing);
            n_err++;
        end
        step(3);
        n_vec++;
        if ({configId, busy} !== {8'hFF, 1'b1}) begin
            $display("FAIL mid_hold got id=%h busy=%b want FF 1", configId, busy);
            n_err++;
        end
        tracing = 1'b0;
        step(3);
        n_vec++;
        if (configId !== 8'hFF) begin
            $display("FAIL mid_redrain got id=%h want FF", configId);
            n_err++;
        end
        grab_frame(obs);
        n_vec++;
        if (obs !== exp_frame(8'd4, 3'd2, 2'd2, 8'h22)) begin
            $display("FAIL mid_next got %h want %h", obs, exp_frame(8'd4, 3'd2, 2'd2, 8'h22));
            n_err++;
        end
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        n_vec++;
        if ({err_tracing, busy} !== 2'b00) begin
            $display("FAIL mid_clear got et=%b busy=%b want 0 0", err_tracing, busy);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        push(8'd5, 3'd0, 2'd0, 8'h01);
        push(8'd6, 3'd1, 2'd1, 8'h02);
        push(8'd7, 3'd2, 2'd2, 8'h03);
        n_vec++;
        if ({configId, configData} !== {8'd5, 8'h00}) begin
            $display("FAIL rst_chain got %h %h want 05 00", configId, configData);
            n_err++;
        end
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({configId, busy, frame_done, cmd_ready} !== {8'hFF, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL rst_async got id=%h busy=%b done=%b rdy=%b want FF 0 0 1",
                     configId, busy, frame_done, cmd_ready);
            n_err++;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (configId !== 8'hFF || busy !== 1'b0) bad = 1'b1;
        end
        n_vec++;
        if (bad !== 1'b0) begin
            $display("FAIL rst_discard got activity=%b want 0", bad);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [58:0] obs;
        logic [58:0] exp [3];
        exp[0] = exp_frame(8'h21, 3'd1, 2'd1, 8'hB1);
        exp[1] = exp_frame(8'h22, 3'd2, 2'd2, 8'hB2);
        exp[2] = exp_frame(8'h23, 3'd3, 2'd3, 8'hB3);
        tracing = 1'b1;
        push(8'h20, 3'd0, 2'd0, 8'hB0);
        push(8'h21, 3'd1, 2'd1, 8'hB1);
        push(8'h22, 3'd2, 2'd2, 8'hB2);
        tracing = 1'b0;
        step(3);
        push(8'h23, 3'd3, 2'd3, 8'hB3);   // same edge as the pop of the head
        n_vec++;
        if ({configId, configData, cmd_ready} !== {8'h20, 8'h00, 1'b1}) begin
            $display("FAIL b2b_pushpop got id=%h data=%h rdy=%b want 20 00 1",
                     configId, configData, cmd_ready);
            n_err++;
        end
        step(2);
        n_vec++;
        if ({configId, configData, frame_done} !== {8'h20, 8'hB0, 1'b1}) begin
            $display("FAIL b2b_value got id=%h data=%h done=%b want 20 B0 1",
                     configId, configData, frame_done);
            n_err++;
        end
        step(1);
        for (int i = 0; i < 3; i++) begin
            grab_frame(obs);
            n_vec++;
            if (obs !== exp[i]) begin
                $display("FAIL b2b_order%0d got %h want %h", i, obs, exp[i]);
                n_err++;
            end
        end
        step(1);
        n_vec++;
        if (busy !== 1'b0) begin
            $display("FAIL b2b_drained got busy=%b want 0", busy);
            n_err++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_backlog();
        test_bad_field();
        test_tracing_mid();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
